// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with an input FIFO.
// Frame = start, 5..8 data bits LSB first, optional even/odd parity, 1 or 2
// stop bits. The frame format and divisor are captured when a byte is popped,
// so reconfiguring mid-frame only affects the following frame.
//
// Handshake: a byte transfers on a rising clk edge where s_valid && s_ready.
// s_ready depends only on registered FIFO occupancy (low when full) and does
// not depend on s_valid. A pop in the same cycle does not raise s_ready.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_FREQ / BAUD_RATE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop, fifo_empty;

  // Serial engine
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d, last_bit_q, last_bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d, stop_ph_q, stop_ph_d;
  logic             tx_q, tx_d, busy_q, busy_d;

  // Frame latch helpers
  logic [7:0]       head_masked;
  logic [DIV_W-1:0] div_eff;
  logic             bit_end, stop_last;

  assign s_ready    = (level_q != LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;

  // Byte at the FIFO head with inactive upper bits cleared, and the divisor to latch
  always_comb begin
    head_masked = mem_q[rd_ptr_q] & (8'hFF >> (2'd3 - cfg_data_bits));
    div_eff     = (cfg_div == '0) ? DEFAULT_DIV : cfg_div;
    bit_end     = (cnt_q == div_q - DIV_W'(1));
    stop_last   = (state_q == S_STOP) && bit_end && (!stop2_q || stop_ph_q);
    push        = s_valid && s_ready;
    pop         = !fifo_empty && ((state_q == S_IDLE) || stop_last);
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Engine next-state: tx_d is the line value for the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    last_bit_d = last_bit_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_ph_d  = stop_ph_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == last_bit_q) begin
            stop_ph_d = 1'b0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          cnt_d     = '0;
          stop_ph_d = 1'b0;
          tx_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_last) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_ph_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    // A pop (from IDLE or the final stop cycle) latches the next frame and starts it
    if (pop) begin
      state_d    = S_START;
      cnt_d      = '0;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      shreg_d    = head_masked;
      div_d      = div_eff;
      last_bit_d = {1'b1, cfg_data_bits};
      par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d  = (^head_masked) ^ (cfg_parity == 2'b10);
      stop2_d    = cfg_stop2;
    end
  end

  // FIFO storage write; contents need no reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(1);
      bit_idx_q  <= '0;
      last_bit_q <= 3'd7;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_ph_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      last_bit_q <= last_bit_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_ph_q  <= stop_ph_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Second-generation UART transmitter. Frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and baud divisor are set at runtime. Bytes enter through a valid/ready stream interface into an internal FIFO, so frames go out back-to-back with no idle gap. The block sits between the byte-producing logic and the serial pin, in place of the fixed 8N1 transmitter.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz; used only to derive DEFAULT_DIV.
BAUD_RATE, 9600, baud rate used for DEFAULT_DIV = CLK_FREQ/BAUD_RATE.
FIFO_DEPTH, 4, entries in the TX FIFO; power of two, ≥2.
DIV_W, 16, width of the runtime divisor.

Ports:
clk  in  1  system clock; the block's single clock
reset  in  1  synchronous reset, active-high
cfg_div  in  DIV_W  clocks per bit; 0 selects DEFAULT_DIV
cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none
cfg_stop2  in  1  0=1 stop bit, 1=2 stop bits
s_valid  in  1  byte offered
s_data  in  8  byte to send; bits above the active width are ignored
s_ready  out  1  FIFO can accept
tx  out  1  serial line, idles high
tx_busy  out  1  frame in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset, synchronous and active-high. Effective the cycle after it is sampled:
  - tx=1, tx_busy=0, s_ready=1, fifo_level=0.
  - FIFO flushed, engine in IDLE.
  - Reset mid-frame aborts the frame immediately; no stop bit is completed.
- FIFO:
  - Push on s_valid && s_ready.
  - s_ready = (fifo_level != FIFO_DEPTH). It is registered-state based, with no bypass when full: a pop in the same cycle does not raise s_ready.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Engine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_busy=0. If the FIFO is non-empty:
    - pop the head;
    - latch the byte, the effective divisor (DEFAULT_DIV if cfg_div==0), data-bit count, parity mode and stop count;
    - go to START.
  - Config changes mid-frame have no effect until the next frame's latch.
  - START: tx=0 for div cycles.
  - DATA: LSB first; N bits, each for div cycles.
  - PARITY: entered only if parity is enabled. Even parity: bit = XOR of the N active bits. Odd parity: the inverse. Lasts div cycles.
  - STOP: tx=1 for div cycles (1 stop) or 2·div cycles (2 stop).
  - At the last cycle of STOP:
    - FIFO non-empty: pop and latch new config in that cycle, go directly to START. No idle cycle; tx_busy stays 1.
    - Otherwise: go to IDLE.
- tx_busy=1 from the cycle tx first drives the start bit through the last stop cycle.
- Latency: byte accepted at cycle N into an empty FIFO with the engine IDLE → popped at N+1 → tx=0 from N+2.
- Frame length = (1 + N + P + S)·div cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Bit-period counter: counts 0..div−1, then advances to the next bit. div=1 is legal: one cycle per bit.
- tx is a registered output, glitch-free.

Test Plan:
- 8N1, cfg_div=4, push 0xA5 while idle → tx=0 at N+2, then bits 1,0,1,0,0,1,0,1, then stop 1; each bit 4 cycles; 40 cycles total; tx_busy high throughout.
- 7E1 and 7O1, div=3, byte 0x41 (7 data bits 1,0,0,0,0,0,1) → even parity bit 0, odd parity bit 1; frame 30 cycles. 0xC1 gives an identical waveform (bit 7 ignored).
- 5O2, div=2, byte 0x1F → data 1,1,1,1,1; odd parity 0; stop held 4 cycles; frame 18 cycles.
- FIFO_DEPTH=4, div=2, 8N1, hold s_valid with 6 distinct bytes:
  - s_ready drops once fifo_level=4;
  - all 6 bytes are sent in order, back-to-back, with no tx=1 gap between stop and next start;
  - tx_busy never drops until the last stop bit;
  - fifo_level ends at 0.
- cfg_div=0 → bit period = DEFAULT_DIV (10416 at default parameters). Changing cfg_data_bits mid-frame does not alter the current frame; it applies to the next frame.
- Assert reset in the middle of the data bits with 2 bytes queued → next cycle tx=1, tx_busy=0, fifo_level=0, s_ready=1. After release, no further frames are sent until a new push.
